svtests_vcd_heartbeat_gen: RTL and testbench
============================================

# svtests_vcd_heartbeat_gen

Parametrised multi-channel heartbeat generator bound under a test's top module. It drives deterministic, clocked activity on output ports so that both Questa_vcd and arcilator always dump a non-trivial, comparable set of signals. It generalises a single fixed counter into N channels with per-channel stride, a prescaler, one-shot/continuous modes, start/abort control and a rolling signature. The signature makes any divergence between simulators visible on one net.

## Interface
- CHANNELS, 4, number of heartbeat counters (>=1)
- WIDTH, 8, bits per counter and signature (>=2)
- LIMIT, 16, ticks per run (>=1)
- PRESCALE, 1, clock cycles per tick (>=1)
- STEP, 1, base increment; channel i adds STEP*(i+1) per tick
- CONTINUOUS, 0, 0 = one-shot, 1 = auto-restart run
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin run (sampled in IDLE or DONE)
- abort  in  1  return to IDLE, clears counters
- counters  out  CHANNELS*WIDTH  packed counters; channel i at [i*WIDTH +: WIDTH]
- tick_count  out  $clog2(LIMIT+1)  ticks completed in current run
- signature  out  WIDTH  rolling signature
- busy  out  1  high in RUN
- done  out  1  run-complete flag

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- IDLE:
  - start=1 -> RUN; clear counters, tick_count, prescaler and signature on the same edge.
- RUN:
  - The prescaler counts 0..PRESCALE-1.
  - When the prescaler is at PRESCALE-1, a tick occurs and the prescaler returns to 0.
- On each tick:
  - cnt_i <= cnt_i + STEP*(i+1), mod 2^WIDTH (wraps silently).
  - tick_count increments.
  - signature <= rotl1(signature) XOR (XOR over all i of new cnt_i).
- Tick that makes tick_count == LIMIT:
  - CONTINUOUS=0: go to DONE; tick_count holds LIMIT.
  - CONTINUOUS=1: stay in RUN; tick_count <= 0; counters and signature keep running (no clear); done pulses high for exactly one cycle.
- DONE:
  - All outputs hold and done=1.
  - start=1 -> RUN with the same clears as from IDLE.
- abort=1 in any state -> IDLE next edge.
  - Clears counters, tick_count, prescaler and done.
  - signature holds its value.
- start and abort high on the same edge: abort wins.
- start while in RUN is ignored.

## Timing
- Reset values: counters=0, tick_count=0, signature=0, busy=0, done=0, state IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- Let E0 be the edge that samples start.
  - busy=1 from E0.
  - First tick lands on edge E0+PRESCALE.
  - Tick k lands on edge E0+k*PRESCALE.
- One-shot completion:
  - done rises and busy falls on edge E0+LIMIT*PRESCALE (same edge as the final tick).
- Continuous mode:
  - done is high for the cycle following edge E0+n*LIMIT*PRESCALE, n>=1.
  - busy stays 1.
- Asynchronous reset mid-run: outputs go to reset values immediately, with no clock required.
  - The first start after rst_n deasserts behaves as from IDLE.

## Test plan
- Defaults (CHANNELS=4, WIDTH=8, LIMIT=16, PRESCALE=1), start pulse at E0 -> at E0+16: counters = 16,32,48,64; tick_count=16; done=1; busy=0. Values hold for 20 further cycles.
- CHANNELS=2, WIDTH=8, LIMIT=3 -> signature after ticks 1/2/3 = 0x03/0x00/0x05; counters end at 3,6.
- WIDTH=4, CHANNELS=2, LIMIT=9 -> channel 1 wraps; final counters = 9, 2.
- PRESCALE=3, LIMIT=4 -> ticks at E0+3/6/9/12 only; done at E0+12.
- CONTINUOUS=1, LIMIT=4 -> done pulses 1 cycle after E0+4 and again after E0+8. At E0+8: tick_count=0, channel 0=8, busy=1 throughout.
- Boundary cases:
  - start+abort on the same edge -> stays IDLE.
  - abort at tick 5 -> counters 0, done 0, signature unchanged.
  - rst_n low mid-run -> all outputs 0 asynchronously.
  - start in DONE -> fresh run, same values as the first scenario.

Source files
------------

// File: rtl/svtests_vcd_heartbeat_gen.sv
// svtests_vcd_heartbeat_gen: multi-channel heartbeat counters with prescaler, run control and rolling signature
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - begin a run from IDLE or DONE
//   abort      - return to IDLE, clearing counters (signature is kept)
//   counters   - packed per-channel counters, channel i at [i*WIDTH +: WIDTH]
//   tick_count - ticks completed in the current run
//   signature  - rotate-left-and-xor digest of every counter update
//   busy       - high while running
//   done       - run-complete flag (level in one-shot, one-cycle pulse in continuous)
module svtests_vcd_heartbeat_gen #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int LIMIT      = 16,
    parameter int PRESCALE   = 1,
    parameter int STEP       = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic [CHANNELS*WIDTH-1:0]    counters,
    output logic [$clog2(LIMIT+1)-1:0]   tick_count,
    output logic [WIDTH-1:0]             signature,
    output logic                         busy,
    output logic                         done
);
    localparam int TW = $clog2(LIMIT + 1);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [PW-1:0]                  pre_q, pre_d;
    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0]                  tick_q, tick_d, tick_inc;
    logic [WIDTH-1:0]               sig_q, sig_d, sig_mix;
    logic                           done_q, done_d;
    logic                           tick, last;

    // Candidate values for the next tick; only committed when a tick occurs.
    always_comb begin
        sig_mix = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_inc[i] = cnt_q[i] + WIDTH'(STEP * (i + 1));
            sig_mix    = sig_mix ^ cnt_inc[i];
        end
    end

    assign tick     = (state_q == RUN) && (pre_q == PW'(PRESCALE - 1));
    assign tick_inc = tick_q + TW'(1);
    assign last     = tick_inc == TW'(LIMIT);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        tick_d  = tick_q;
        sig_d   = sig_q;
        done_d  = done_q;
        if (abort) begin
            // abort dominates start; signature deliberately survives
            state_d = IDLE;
            pre_d   = '0;
            cnt_d   = '0;
            tick_d  = '0;
            done_d  = 1'b0;
        end else if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                pre_d   = '0;
                cnt_d   = '0;
                tick_d  = '0;
                sig_d   = '0;
                done_d  = 1'b0;
            end
        end else begin
            // in RUN done only stays high on the cycle after a completing tick
            done_d = 1'b0;
            pre_d  = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                cnt_d  = cnt_inc;
                sig_d  = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ sig_mix;
                tick_d = tick_inc;
                if (last) begin
                    done_d = 1'b1;
                    if (CONTINUOUS != 0) tick_d = '0;
                    else state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= '0;
            sig_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
        end
    end

    assign counters   = cnt_q;
    assign tick_count = tick_q;
    assign signature  = sig_q;
    assign busy       = state_q == RUN;
    assign done       = done_q;
endmodule

// File: tb/tb_svtests_vcd_heartbeat_gen.sv
// tb_svtests_vcd_heartbeat_gen: five parameterisations driven in lockstep, table vectors plus corner sequences
module tb_svtests_vcd_heartbeat_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] c0; logic [4:0] t0; logic [7:0] s0; logic b0, d0;
    logic [15:0] c1; logic [1:0] t1; logic [7:0] s1; logic b1, d1;
    logic [7:0]  c2; logic [3:0] t2; logic [3:0] s2; logic b2, d2;
    logic [31:0] c3; logic [2:0] t3; logic [7:0] s3; logic b3, d3;
    logic [31:0] c4; logic [2:0] t4; logic [7:0] s4; logic b4, d4;

    svtests_vcd_heartbeat_gen u0 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .counters(c0), .tick_count(t0), .signature(s0), .busy(b0), .done(d0));
    svtests_vcd_heartbeat_gen #(.CHANNELS(2), .LIMIT(3)) u1 (.clk(clk), .rst_n(rst_n),
        .start(start), .abort(abort), .counters(c1), .tick_count(t1), .signature(s1), .busy(b1), .done(d1));
    svtests_vcd_heartbeat_gen #(.CHANNELS(2), .WIDTH(4), .LIMIT(9)) u2 (.clk(clk), .rst_n(rst_n),
        .start(start), .abort(abort), .counters(c2), .tick_count(t2), .signature(s2), .busy(b2), .done(d2));
    svtests_vcd_heartbeat_gen #(.LIMIT(4), .PRESCALE(3)) u3 (.clk(clk), .rst_n(rst_n),
        .start(start), .abort(abort), .counters(c3), .tick_count(t3), .signature(s3), .busy(b3), .done(d3));
    svtests_vcd_heartbeat_gen #(.LIMIT(4), .CONTINUOUS(1)) u4 (.clk(clk), .rst_n(rst_n),
        .start(start), .abort(abort), .counters(c4), .tick_count(t4), .signature(s4), .busy(b4), .done(d4));

    typedef struct {
        int          cyc;
        int          id;
        logic [63:0] cnt;
        int          tick;
        int          sig;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic add(input int cyc, input int id, input logic [63:0] cnt, input int tick,
                       input int sig, input logic busy, input logic done);
        vec_t v;
        v.cyc = cyc; v.id = id; v.cnt = cnt; v.tick = tick; v.sig = sig; v.busy = busy; v.done = done;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic get(input int id, output logic [63:0] c, output int t, output int s,
                       output logic b, output logic d);
        case (id)
            0: begin c = 64'(c0); t = int'(t0); s = int'(s0); b = b0; d = d0; end
            1: begin c = 64'(c1); t = int'(t1); s = int'(s1); b = b1; d = d1; end
            2: begin c = 64'(c2); t = int'(t2); s = int'(s2); b = b2; d = d2; end
            3: begin c = 64'(c3); t = int'(t3); s = int'(s3); b = b3; d = d3; end
            default: begin c = 64'(c4); t = int'(t4); s = int'(s4); b = b4; d = d4; end
        endcase
    endtask

    // Reference signature after n ticks from a cleared start, STEP = 1.
    function automatic int sig_model(input int n, input int ch, input int w);
        int mask = (1 << w) - 1;
        int s = 0;
        for (int t = 1; t <= n; t++) begin
            int x = 0;
            for (int i = 0; i < ch; i++) x = x ^ ((t * (i + 1)) & mask);
            s = (((s << 1) | (s >> (w - 1))) & mask) ^ x;
        end
        return s;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_table(input int pass);
        logic [63:0] c; int t, s; logic b, d;
        pulse_start();
        for (int cyc = 0; cyc <= 40; cyc++) begin
            foreach (vecs[j]) begin
                if (vecs[j].cyc == cyc && !(pass > 0 && vecs[j].id == 4)) begin
                    string nm;
                    nm = $sformatf("p%0d_d%0d_c%0d", pass, vecs[j].id, cyc);
                    get(vecs[j].id, c, t, s, b, d);
                    chk({nm, "_cnt"}, c, vecs[j].cnt);
                    chk({nm, "_tick"}, 64'(t), 64'(vecs[j].tick));
                    chk({nm, "_busy"}, 64'(b), 64'(vecs[j].busy));
                    chk({nm, "_done"}, 64'(d), 64'(vecs[j].done));
                    if (vecs[j].sig >= 0) chk({nm, "_sig"}, 64'(s), 64'(vecs[j].sig));
                end
            end
            if (pass == 0) chk($sformatf("cont_busy_c%0d", cyc), 64'(b4), 64'(1));
            @(negedge clk);
        end
    endtask

    initial begin
        // defaults: counters k,2k,3k,4k
        add(0,  0, 64'h0,        0,  -1, 1, 0);
        add(1,  0, 64'h04030201, 1,  4,  1, 0);
        add(5,  0, 64'h140F0A05, 5,  -1, 1, 0);
        add(15, 0, 64'h3C2D1E0F, 15, -1, 1, 0);
        add(16, 0, 64'h40302010, 16, sig_model(16, 4, 8), 0, 1);
        add(36, 0, 64'h40302010, 16, sig_model(16, 4, 8), 0, 1);
        // two channels, LIMIT 3
        add(1, 1, 64'h0201, 1, 8'h03, 1, 0);
        add(2, 1, 64'h0402, 2, 8'h00, 1, 0);
        add(3, 1, 64'h0603, 3, 8'h05, 0, 1);
        // 4-bit counters, channel 1 wraps
        add(8, 2, 64'h08, 8, -1, 1, 0);
        add(9, 2, 64'h29, 9, sig_model(9, 2, 4), 0, 1);
        // prescaler 3
        add(2,  3, 64'h0,        0, -1, 1, 0);
        add(3,  3, 64'h04030201, 1, -1, 1, 0);
        add(5,  3, 64'h04030201, 1, -1, 1, 0);
        add(6,  3, 64'h08060402, 2, -1, 1, 0);
        add(11, 3, 64'h0C090603, 3, -1, 1, 0);
        add(12, 3, 64'h100C0804, 4, -1, 0, 1);
        // continuous LIMIT 4
        add(3,  4, 64'h0C090603, 3, -1, 1, 0);
        add(4,  4, 64'h100C0804, 0, -1, 1, 1);
        add(5,  4, 64'h140F0A05, 1, -1, 1, 0);
        add(8,  4, 64'h20181008, 0, -1, 1, 1);
        add(9,  4, 64'h241B1209, 1, -1, 1, 0);
        add(36, 4, 64'h906C4824, 0, -1, 1, 1);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_cnt", 64'(c0), 64'h0);
        chk("rst_sig", 64'(s0), 64'h0);
        chk("rst_busy", 64'(b0), 64'h0);
        chk("rst_done", 64'(d0), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tick", 64'(t0), 64'h0);

        run_table(0);
        // every one-shot instance is now in DONE: restart must reproduce the same run
        run_table(1);

        // start and abort together from DONE: abort wins, signature held
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk("sa_busy", 64'(b0), 64'h0);
        chk("sa_done", 64'(d0), 64'h0);
        chk("sa_cnt", 64'(c0), 64'h0);
        chk("sa_tick", 64'(t0), 64'h0);
        chk("sa_sig", 64'(s0), 64'(sig_model(16, 4, 8)));
        chk("sa_cont_busy", 64'(b4), 64'h0);
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk("sa_idle_busy", 64'(b0), 64'h0);
        @(negedge clk);
        chk("sa_idle_cnt", 64'(c0), 64'h0);

        // abort at tick 5
        pulse_start();
        repeat (5) @(negedge clk);
        chk("ab_tick5", 64'(t0), 64'h5);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("ab_cnt", 64'(c0), 64'h0);
        chk("ab_tick", 64'(t0), 64'h0);
        chk("ab_done", 64'(d0), 64'h0);
        chk("ab_busy", 64'(b0), 64'h0);
        chk("ab_sig", 64'(s0), 64'(sig_model(5, 4, 8)));
        chk("ab_cont_busy", 64'(b4), 64'h0);

        // asynchronous reset mid-run, no clock edge between assert and check
        pulse_start();
        repeat (2) @(negedge clk);
        chk("ar_pre_tick", 64'(t0), 64'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cnt", 64'(c0), 64'h0);
        chk("ar_tick", 64'(t0), 64'h0);
        chk("ar_sig", 64'(s0), 64'h0);
        chk("ar_busy", 64'(b0), 64'h0);
        chk("ar_cont_busy", 64'(b4), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        chk("ar_restart_busy", 64'(b0), 64'h1);
        @(negedge clk);
        chk("ar_restart_cnt", 64'(c0), 64'h04030201);
        chk("ar_restart_tick", 64'(t0), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
